// File: rtl/lmsm_sequencer.sv
// LM/SM micro-op sequencer for the ID stage.
// Splits one register list into per-register load/store micro-ops.
module lmsm_sequencer #(
  parameter int          LIST_W = 8,
  parameter int          OFF_W  = 16,
  parameter logic [3:0]  OPC_LM = 4'b0110,
  parameter logic [3:0]  OPC_SM = 4'b0111,
  localparam int         SEL_W  = $clog2(LIST_W)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [15:0]      ir_id,
  input  logic             stall,
  input  logic             flush,
  output logic             part_stall,
  output logic [15:0]      ir_next,
  output logic [SEL_W-1:0] reg_sel,
  output logic [OFF_W-1:0] mem_offset,
  output logic             uop_valid,
  output logic             uop_is_load,
  output logic             uop_last,
  output logic             busy
);

  typedef enum logic {
    IDLE,
    SEQ
  } state_t;

  state_t              state_q, state_d;
  logic [LIST_W-1:0]   mask_q, mask_d;
  logic [OFF_W-1:0]    off_q, off_d;

  logic [3:0]          opc;
  logic                is_lmsm;
  logic                active;
  logic [LIST_W-1:0]   list;
  logic [LIST_W-1:0]   onehot;
  logic [LIST_W-1:0]   remaining;
  logic [SEL_W-1:0]    sel;

  always_comb begin
    opc       = ir_id[15:12];
    is_lmsm   = (opc == OPC_LM) || (opc == OPC_SM);
    list      = (state_q == IDLE) ? ir_id[LIST_W-1:0] : mask_q;
    onehot    = list & (~list + 1'b1);
    remaining = list & ~onehot;
    sel       = '0;
    for (int i = LIST_W - 1; i >= 0; i--) begin
      if (list[i]) sel = SEL_W'(i);
    end
    active = (state_q == SEQ) || (is_lmsm && (list != '0));
  end

  // Outputs are combinational and held at zero while reset is asserted.
  always_comb begin
    part_stall  = 1'b0;
    ir_next     = '0;
    reg_sel     = '0;
    mem_offset  = '0;
    uop_valid   = 1'b0;
    uop_is_load = 1'b0;
    uop_last    = 1'b0;
    busy        = 1'b0;
    if (rst && active) begin
      uop_valid   = !flush;
      uop_is_load = (opc == OPC_LM);
      uop_last    = (remaining == '0);
      part_stall  = (remaining != '0);
      reg_sel     = sel;
      mem_offset  = (state_q == SEQ) ? off_q : '0;
      busy        = (state_q == SEQ);
      ir_next     = {ir_id[15:LIST_W], remaining};
    end
  end

  always_comb begin
    state_d = state_q;
    mask_d  = mask_q;
    off_d   = off_q;
    if (flush) begin
      state_d = IDLE;
      mask_d  = '0;
      off_d   = '0;
    end else if (!stall) begin
      unique case (state_q)
        IDLE: begin
          if (active && (remaining != '0)) begin
            state_d = SEQ;
            mask_d  = remaining;
            off_d   = OFF_W'(1);
          end
        end
        SEQ: begin
          if (remaining != '0) begin
            mask_d = remaining;
            off_d  = off_q + OFF_W'(1);
          end else begin
            state_d = IDLE;
            mask_d  = '0;
            off_d   = '0;
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      mask_q  <= '0;
      off_q   <= '0;
    end else begin
      state_q <= state_d;
      mask_q  <= mask_d;
      off_q   <= off_d;
    end
  end

endmodule

// File: tb/tb_lmsm_sequencer.sv
// Directed bench for lmsm_sequencer.
// Models the IF/ID IR reload with hand-computed ir_id values.
module tb_lmsm_sequencer;

  logic        clk;
  logic        rst;
  logic [15:0] ir_id;
  logic        stall;
  logic        flush;
  logic        part_stall;
  logic [15:0] ir_next;
  logic [2:0]  reg_sel;
  logic [15:0] mem_offset;
  logic        uop_valid;
  logic        uop_is_load;
  logic        uop_last;
  logic        busy;
  logic [39:0] got;

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] ir;
    logic        st;
    logic        fl;
    logic [39:0] exp;
  } vec_t;

  lmsm_sequencer dut (
    .clk        (clk),
    .rst        (rst),
    .ir_id      (ir_id),
    .stall      (stall),
    .flush      (flush),
    .part_stall (part_stall),
    .ir_next    (ir_next),
    .reg_sel    (reg_sel),
    .mem_offset (mem_offset),
    .uop_valid  (uop_valid),
    .uop_is_load(uop_is_load),
    .uop_last   (uop_last),
    .busy       (busy)
  );

  assign got = {uop_valid, uop_is_load, uop_last, part_stall, busy,
                reg_sel, mem_offset, ir_next};

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [39:0] mk(
    logic v, logic l, logic la, logic ps, logic b,
    logic [2:0] rs, logic [15:0] off, logic [15:0] irn);
    return {v, l, la, ps, b, rs, off, irn};
  endfunction

  localparam logic [39:0] Z = 40'h0;

  task automatic test_reset();
    rst   = 1'b0;
    ir_id = 16'h60A5;
    stall = 1'b0;
    flush = 1'b0;
    #2;
    checks++;
    if (got !== Z) begin
      errors++;
      $display("FAIL reset_t0 got %h exp %h", got, Z);
    end
    @(negedge clk);
    checks++;
    if (got !== Z) begin
      errors++;
      $display("FAIL reset_hold got %h exp %h", got, Z);
    end
    @(posedge clk);
    #1 rst = 1'b1;
  endtask

  task automatic test_lm_a5();
    vec_t v[$];
    v.push_back('{16'h60A5, 1'b0, 1'b0, mk(1,1,0,1,0,0,0,16'h60A4)});
    v.push_back('{16'h60A4, 1'b0, 1'b0, mk(1,1,0,1,1,2,1,16'h60A0)});
    v.push_back('{16'h60A0, 1'b0, 1'b0, mk(1,1,0,1,1,5,2,16'h6080)});
    v.push_back('{16'h6080, 1'b0, 1'b0, mk(1,1,1,0,1,7,3,16'h6000)});
    v.push_back('{16'h0000, 1'b0, 1'b0, Z});
    foreach (v[i]) begin
      ir_id = v[i].ir;
      stall = v[i].st;
      flush = v[i].fl;
      @(negedge clk);
      checks++;
      if (got !== v[i].exp) begin
        errors++;
        $display("FAIL lm_a5[%0d] got %h exp %h", i, got, v[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_sm_single();
    vec_t v[$];
    v.push_back('{16'h7080, 1'b0, 1'b0, mk(1,0,1,0,0,7,0,16'h7000)});
    v.push_back('{16'h0000, 1'b0, 1'b0, Z});
    foreach (v[i]) begin
      ir_id = v[i].ir;
      stall = v[i].st;
      flush = v[i].fl;
      @(negedge clk);
      checks++;
      if (got !== v[i].exp) begin
        errors++;
        $display("FAIL sm_single[%0d] got %h exp %h", i, got, v[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_nop();
    vec_t v[$];
    v.push_back('{16'h6000, 1'b0, 1'b0, Z});
    v.push_back('{16'h6000, 1'b0, 1'b0, Z});
    v.push_back('{16'h1234, 1'b0, 1'b0, Z});
    v.push_back('{16'h1234, 1'b0, 1'b0, Z});
    foreach (v[i]) begin
      ir_id = v[i].ir;
      stall = v[i].st;
      flush = v[i].fl;
      @(negedge clk);
      checks++;
      if (got !== v[i].exp) begin
        errors++;
        $display("FAIL nop[%0d] got %h exp %h", i, got, v[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  task automatic test_stall();
    vec_t v[$];
    v.push_back('{16'h600F, 1'b0, 1'b0, mk(1,1,0,1,0,0,0,16'h600E)});
    v.push_back('{16'h600E, 1'b1, 1'b0, mk(1,1,0,1,1,1,1,16'h600C)});
    v.push_back('{16'h600E, 1'b1, 1'b0, mk(1,1,0,1,1,1,1,16'h600C)});
    v.push_back('{16'h600E, 1'b0, 1'b0, mk(1,1,0,1,1,1,1,16'h600C)});
    v.push_back('{16'h600C, 1'b0, 1'b0, mk(1,1,0,1,1,2,2,16'h6008)});
    v.push_back('{16'h6008, 1'b0, 1'b0, mk(1,1,1,0,1,3,3,16'h6000)});
    v.push_back('{16'h0000, 1'b0, 1'b0, Z});
    foreach (v[i]) begin
      ir_id = v[i].ir;
      stall = v[i].st;
      flush = v[i].fl;
      @(negedge clk);
      checks++;
      if (got !== v[i].exp) begin
        errors++;
        $display("FAIL stall[%0d] got %h exp %h", i, got, v[i].exp);
      end
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
  endtask

  task automatic test_flush();
    vec_t v[$];
    v.push_back('{16'h60FF, 1'b0, 1'b0, mk(1,1,0,1,0,0,0,16'h60FE)});
    v.push_back('{16'h60FE, 1'b0, 1'b0, mk(1,1,0,1,1,1,1,16'h60FC)});
    v.push_back('{16'h60FC, 1'b0, 1'b1, mk(0,1,0,1,1,2,2,16'h60F8)});
    v.push_back('{16'h0000, 1'b0, 1'b0, Z});
    v.push_back('{16'h60FF, 1'b0, 1'b0, mk(1,1,0,1,0,0,0,16'h60FE)});
    v.push_back('{16'h60FE, 1'b0, 1'b0, mk(1,1,0,1,1,1,1,16'h60FC)});
    v.push_back('{16'h60FC, 1'b1, 1'b1, mk(0,1,0,1,1,2,2,16'h60F8)});
    v.push_back('{16'h0000, 1'b0, 1'b0, Z});
    foreach (v[i]) begin
      ir_id = v[i].ir;
      stall = v[i].st;
      flush = v[i].fl;
      @(negedge clk);
      checks++;
      if (got !== v[i].exp) begin
        errors++;
        $display("FAIL flush[%0d] got %h exp %h", i, got, v[i].exp);
      end
      @(posedge clk);
      #1;
    end
    stall = 1'b0;
    flush = 1'b0;
  endtask

  task automatic test_mid_reset();
    vec_t v[$];
    logic [39:0] e0;
    e0 = mk(1,1,0,1,0,4,0,16'h60E0);
    ir_id = 16'h60F0;
    @(negedge clk);
    checks++;
    if (got !== e0) begin
      errors++;
      $display("FAIL mrst_first got %h exp %h", got, e0);
    end
    @(posedge clk);
    #1 ir_id = 16'h60E0;
    @(negedge clk);
    checks++;
    if (got !== mk(1,1,0,1,1,5,1,16'h60C0)) begin
      errors++;
      $display("FAIL mrst_second got %h exp %h", got,
               mk(1,1,0,1,1,5,1,16'h60C0));
    end
    #1 rst = 1'b0;
    #1;
    checks++;
    if (got !== Z) begin
      errors++;
      $display("FAIL mrst_async got %h exp %h", got, Z);
    end
    @(posedge clk);
    #1 ir_id = 16'h60F0;
    checks++;
    if (got !== Z) begin
      errors++;
      $display("FAIL mrst_hold got %h exp %h", got, Z);
    end
    #2 rst = 1'b1;
    v.push_back('{16'h60F0, 1'b0, 1'b0, e0});
    v.push_back('{16'h60E0, 1'b0, 1'b0, mk(1,1,0,1,1,5,1,16'h60C0)});
    v.push_back('{16'h60C0, 1'b0, 1'b0, mk(1,1,0,1,1,6,2,16'h6080)});
    v.push_back('{16'h6080, 1'b0, 1'b0, mk(1,1,1,0,1,7,3,16'h6000)});
    v.push_back('{16'h0000, 1'b0, 1'b0, Z});
    foreach (v[i]) begin
      ir_id = v[i].ir;
      stall = v[i].st;
      flush = v[i].fl;
      @(negedge clk);
      checks++;
      if (got !== v[i].exp) begin
        errors++;
        $display("FAIL mrst_restart[%0d] got %h exp %h", i, got, v[i].exp);
      end
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    test_reset();
    test_lm_a5();
    test_sm_single();
    test_nop();
    test_stall();
    test_flush();
    test_mid_reset();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
